// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between fetch and data access, in-order tags.
// MEM_ARB_PERF_EN adds grant/kill/conflict performance counters.
module mem_port_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  input  logic [XLEN-1:0]   if_req_addr,
  output logic              if_req_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [XLEN-1:0]   if_rsp_data,
  input  logic              dm_req_valid,
  input  logic [XLEN-1:0]   dm_req_addr,
  input  logic              dm_req_we,
  input  logic [XLEN-1:0]   dm_req_wdata,
  input  logic [XLEN/8-1:0] dm_req_be,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [XLEN-1:0]   dm_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_be,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_data,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_killed,
  output logic [31:0]       perf_conflicts,
`endif
  output logic              busy
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [MAX_OUTSTANDING-1:0] q_id;
  logic [MAX_OUTSTANDING-1:0] q_kill;
  logic [MAX_OUTSTANDING-1:0] q_st;
  logic [AW-1:0]              wptr;
  logic [AW-1:0]              rptr;
  logic [CW-1:0]              count;
  logic [SW-1:0]              starve_cnt;

  logic full;
  logic empty;
  logic dm_win;
  logic if_win;
  logic accept;
  logic push;
  logic pop;
  logic head_id;
  logic head_kill;
  logic if_acc;

  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  // With fetch idle, a saturated starve count must not block data.
  assign dm_win = dm_req_valid &
                  (!if_req_valid ||
                   (starve_cnt < SW'(STARVE_LIMIT)));
  assign if_win = !dm_win & if_req_valid;

  assign mem_req_valid = (dm_req_valid | if_req_valid) &
                         !full & !reset;
  assign mem_req_addr  = dm_win ? dm_req_addr : if_req_addr;
  assign mem_req_we    = dm_win & dm_req_we;
  assign mem_req_wdata = dm_win ? dm_req_wdata : '0;
  assign mem_req_be    = dm_win ? dm_req_be : '1;

  assign accept       = mem_req_valid & mem_req_ready;
  assign if_req_ready = accept & if_win;
  assign dm_req_ready = accept & dm_win;
  assign if_acc       = if_req_ready;

  assign push      = accept;
  assign pop       = mem_rsp_valid & !empty;
  assign head_id   = q_id[rptr];
  assign head_kill = q_kill[rptr] | if_flush;

  assign busy = !empty;

  // Tag storage; a same-cycle push overrides the flush mark on its slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (if_flush && !q_id[i])
        q_kill[i] <= 1'b1;
    end
    if (push) begin
      q_id[wptr]   <= dm_win;
      q_kill[wptr] <= 1'b0;
      q_st[wptr]   <= dm_win & dm_req_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      starve_cnt   <= '0;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      dm_rsp_valid <= 1'b0;
      dm_rsp_data  <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);

      if (if_req_valid && !if_acc) begin
        if (starve_cnt < SW'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end

      if_rsp_valid <= pop & !head_id & !head_kill;
      if (pop && !head_id && !head_kill)
        if_rsp_data <= mem_rsp_data;

      dm_rsp_valid <= pop & head_id;
      if (pop && head_id)
        dm_rsp_data <= q_st[rptr] ? '0 : mem_rsp_data;
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_grants <= '0;
      perf_dm_grants <= '0;
      perf_killed    <= '0;
      perf_conflicts <= '0;
    end else begin
      if (if_acc)
        perf_if_grants <= perf_if_grants + 32'd1;
      if (dm_req_ready)
        perf_dm_grants <= perf_dm_grants + 32'd1;
      if (pop && !head_id && head_kill)
        perf_killed <= perf_killed + 32'd1;
      if (if_req_valid && dm_req_valid)
        perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, starvation, flush,
// FIFO full and reset recovery.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid;
  logic [31:0] dm_req_addr;
  logic        dm_req_we;
  logic [31:0] dm_req_wdata;
  logic [3:0]  dm_req_be;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [31:0] dm_rsp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        busy;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_grants;
  logic [31:0] perf_dm_grants;
  logic [31:0] perf_killed;
  logic [31:0] perf_conflicts;
`endif

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .XLEN(32),
    .MAX_OUTSTANDING(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req_valid(if_req_valid),
    .if_req_addr(if_req_addr),
    .if_req_ready(if_req_ready),
    .if_flush(if_flush),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid),
    .dm_req_addr(dm_req_addr),
    .dm_req_we(dm_req_we),
    .dm_req_wdata(dm_req_wdata),
    .dm_req_be(dm_req_be),
    .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid),
    .dm_rsp_data(dm_rsp_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_be(mem_req_be),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
`ifdef MEM_ARB_PERF_EN
    .perf_if_grants(perf_if_grants),
    .perf_dm_grants(perf_dm_grants),
    .perf_killed(perf_killed),
    .perf_conflicts(perf_conflicts),
`endif
    .busy(busy)
  );

  task automatic idle();
    if_req_valid  = 1'b0;
    if_req_addr   = '0;
    if_flush      = 1'b0;
    dm_req_valid  = 1'b0;
    dm_req_addr   = '0;
    dm_req_we     = 1'b0;
    dm_req_wdata  = '0;
    dm_req_be     = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    if_req_valid = 1'b1;
    dm_req_valid = 1'b1;
    #1;
    nvec++;
    if (mem_req_valid !== 1'b0) begin
      nfail++;
      $display("FAIL rst_mem_req_valid got %b want 0", mem_req_valid);
    end
    nvec++;
    if ({if_req_ready, dm_req_ready} !== 2'b00) begin
      nfail++;
      $display("FAIL rst_ready got %b want 00",
               {if_req_ready, dm_req_ready});
    end
    nvec++;
    if ({if_rsp_valid, dm_rsp_valid, busy} !== 3'b000) begin
      nfail++;
      $display("FAIL rst_flags got %b want 000",
               {if_rsp_valid, dm_rsp_valid, busy});
    end
    nvec++;
    if ({if_rsp_data, dm_rsp_data} !== 64'h0) begin
      nfail++;
      $display("FAIL rst_data got %h want 0",
               {if_rsp_data, dm_rsp_data});
    end
    @(negedge clk);
    idle();
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h10;
    #1;
    nvec++;
    if ({mem_req_valid, if_req_ready, mem_req_we} !== 3'b110 ||
        mem_req_addr !== 32'h10 || mem_req_be !== 4'hF) begin
      nfail++;
      $display("FAIL fetch_req got v%b r%b we%b a%h be%h want 1 1 0 10 f",
               mem_req_valid, if_req_ready, mem_req_we,
               mem_req_addr, mem_req_be);
    end
    @(negedge clk);
    idle();
    #1;
    nvec++;
    if (busy !== 1'b1 || if_rsp_valid !== 1'b0) begin
      nfail++;
      $display("FAIL fetch_busy got b%b v%b want b1 v0",
               busy, if_rsp_valid);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h00500093;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    #1;
    nvec++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h00500093 ||
        busy !== 1'b0) begin
      nfail++;
      $display("FAIL fetch_rsp got v%b d%h b%b want v1 d00500093 b0",
               if_rsp_valid, if_rsp_data, busy);
    end
    @(negedge clk);
    #1;
    nvec++;
    if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h00500093) begin
      nfail++;
      $display("FAIL fetch_pulse got v%b d%h want v0 d00500093",
               if_rsp_valid, if_rsp_data);
    end
  endtask

  task automatic test_store_priority();
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr  = 32'h20;
    dm_req_valid = 1'b1;
    dm_req_addr  = 32'h100;
    dm_req_we    = 1'b1;
    dm_req_wdata = 32'hAA;
    dm_req_be    = 4'b0001;
    #1;
    nvec++;
    if ({if_req_ready, dm_req_ready, mem_req_we} !== 3'b011 ||
        mem_req_be !== 4'b0001 || mem_req_addr !== 32'h100 ||
        mem_req_wdata !== 32'hAA) begin
      nfail++;
      $display("FAIL st_win got ir%b dr%b we%b be%b a%h wd%h want 0 1 1 0001 100 aa",
               if_req_ready, dm_req_ready, mem_req_we, mem_req_be,
               mem_req_addr, mem_req_wdata);
    end
    @(negedge clk);
    dm_req_valid = 1'b0;
    #1;
    nvec++;
    if (if_req_ready !== 1'b1 || mem_req_addr !== 32'h20 ||
        mem_req_we !== 1'b0 || mem_req_be !== 4'hF) begin
      nfail++;
      $display("FAIL st_next got ir%b a%h we%b be%h want 1 20 0 f",
               if_req_ready, mem_req_addr, mem_req_we, mem_req_be);
    end
    @(negedge clk);
    idle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEADBEEF;
    @(negedge clk);
    mem_rsp_data = 32'h00000013;
    #1;
    nvec++;
    if (dm_rsp_valid !== 1'b1 || dm_rsp_data !== 32'h0 ||
        if_rsp_valid !== 1'b0) begin
      nfail++;
      $display("FAIL st_ack got v%b d%h iv%b want v1 d0 iv0",
               dm_rsp_valid, dm_rsp_data, if_rsp_valid);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    nvec++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h13 ||
        dm_rsp_valid !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL st_fetch_rsp got iv%b d%h dv%b b%b want 1 13 0 0",
               if_rsp_valid, if_rsp_data, dm_rsp_valid, busy);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    dm_req_valid = 1'b1;
    dm_req_addr  = 32'h300;
    dm_req_be    = 4'hF;
    @(negedge clk);
    idle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h12345678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    nvec++;
    if (dm_rsp_valid !== 1'b1 || dm_rsp_data !== 32'h12345678) begin
      nfail++;
      $display("FAIL load_rsp got v%b d%h want v1 d12345678",
               dm_rsp_valid, dm_rsp_data);
    end
  endtask

  task automatic test_starve();
    @(negedge clk);
    if_req_valid  = 1'b1;
    if_req_addr   = 32'h80;
    dm_req_valid  = 1'b1;
    dm_req_addr   = 32'h200;
    dm_req_be     = 4'hF;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h55;
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      nvec++;
      if (if_req_ready !== (i == 9) || dm_req_ready !== (i != 9)) begin
        nfail++;
        $display("FAIL starve_c%0d got ir%b dr%b want ir%b dr%b",
                 i, if_req_ready, dm_req_ready, i == 9, i != 9);
      end
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    @(negedge clk);
    idle();
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL starve_drain got b%b want 0", busy);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_req_valid = 1'b1;
      if_req_addr  = 32'h30 + 32'(4 * i);
    end
    @(negedge clk);
    if_req_addr   = 32'h40;
    if_flush      = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1;
    #1;
    nvec++;
    if (if_req_ready !== 1'b1 || mem_req_addr !== 32'h40) begin
      nfail++;
      $display("FAIL flush_accept got r%b a%h want r1 a40",
               if_req_ready, mem_req_addr);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if_req_valid  = 1'b0;
      if_flush      = 1'b0;
      mem_rsp_valid = (k < 4);
      mem_rsp_data  = (k == 3) ? 32'h44 : 32'(k + 1);
      #1;
      nvec++;
      if (if_rsp_valid !== (k == 4)) begin
        nfail++;
        $display("FAIL flush_pulse_%0d got %b want %b",
                 k, if_rsp_valid, k == 4);
      end
    end
    nvec++;
    if (if_rsp_data !== 32'h44 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL flush_data got d%h b%b want d44 b0",
               if_rsp_data, busy);
    end
    idle();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if_req_valid  = 1'b1;
      if_req_addr   = 32'h50;
      mem_rsp_valid = (i == 7);
      mem_rsp_data  = 32'h77;
      #1;
      nvec++;
      if (if_req_ready !== (i <= 4 || i == 8) ||
          mem_req_valid !== (i <= 4 || i == 8)) begin
        nfail++;
        $display("FAIL full_c%0d got r%b v%b want %b",
                 i, if_req_ready, mem_req_valid, i <= 4 || i == 8);
      end
    end
    @(negedge clk);
    idle();
    mem_rsp_valid = 1'b1;
    repeat (4) @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL full_drain got b%b want 0", busy);
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if_req_valid = 1'b1;
      if_req_addr  = 32'h60 + 32'(4 * i);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    nvec++;
    if (mem_req_valid !== 1'b0 || if_req_ready !== 1'b0) begin
      nfail++;
      $display("FAIL rst_mid_req got v%b r%b want 0 0",
               mem_req_valid, if_req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hBAD;
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL rst_mid_busy got %b want 0", busy);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    nvec++;
    if ({if_rsp_valid, dm_rsp_valid, busy} !== 3'b000 ||
        if_rsp_data !== 32'h0) begin
      nfail++;
      $display("FAIL rst_stray got %b d%h want 000 d0",
               {if_rsp_valid, dm_rsp_valid, busy}, if_rsp_data);
    end
    if_req_valid = 1'b1;
    if_req_addr  = 32'h70;
    #1;
    nvec++;
    if (if_req_ready !== 1'b1) begin
      nfail++;
      $display("FAIL rst_new_req got %b want 1", if_req_ready);
    end
    @(negedge clk);
    idle();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h00700001;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
    nvec++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h00700001) begin
      nfail++;
      $display("FAIL rst_new_rsp got v%b d%h want v1 d00700001",
               if_rsp_valid, if_rsp_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_priority();
    test_load();
    test_starve();
    test_flush();
    test_full();
    test_reset_midflight();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
